// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the parametrised VGA timing generator.
// Holds the standard mode sets and the line/frame total calculation.
package vga_timing_pkg;

    localparam int CNT_W = 11;

    // 1024x768 @ 70 Hz, 75 MHz pixel clock
    localparam int XGA_H_ACTIVE = 1024;
    localparam int XGA_H_FP     = 24;
    localparam int XGA_H_SYNC   = 136;
    localparam int XGA_H_BP     = 144;
    localparam int XGA_V_ACTIVE = 768;
    localparam int XGA_V_FP     = 3;
    localparam int XGA_V_SYNC   = 6;
    localparam int XGA_V_BP     = 29;
    localparam bit XGA_H_POL    = 1'b0;
    localparam bit XGA_V_POL    = 1'b0;

    // 800x600 @ 60 Hz, 40 MHz pixel clock
    localparam int SVGA_H_ACTIVE = 800;
    localparam int SVGA_H_FP     = 40;
    localparam int SVGA_H_SYNC   = 128;
    localparam int SVGA_H_BP     = 88;
    localparam int SVGA_V_ACTIVE = 600;
    localparam int SVGA_V_FP     = 1;
    localparam int SVGA_V_SYNC   = 4;
    localparam int SVGA_V_BP     = 23;
    localparam bit SVGA_H_POL    = 1'b1;
    localparam bit SVGA_V_POL    = 1'b1;

    function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Timing bus between the generator (master) and the background stage (slave).
// frame_cnt exists only when VGA_TIMING_FRAME_CNT_EN is defined.
interface vga_timing_if #(
    parameter int CNT_W = vga_timing_pkg::CNT_W
);
    logic             ce;
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
    logic             line_start;
    logic             frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0]      frame_cnt;

    modport master (input ce, output hcount, vcount, hsync, vsync, hblnk, vblnk,
                    line_start, frame_start, frame_cnt);
    modport slave  (output ce, input hcount, vcount, hsync, vsync, hblnk, vblnk,
                    line_start, frame_start, frame_cnt);
`else
    modport master (input ce, output hcount, vcount, hsync, vsync, hblnk, vblnk,
                    line_start, frame_start);
    modport slave  (output ce, input hcount, vcount, hsync, vsync, hblnk, vblnk,
                    line_start, frame_start);
`endif
endinterface

// File: rtl/vga_timing_axis.sv
// One timing axis: wrapping position counter with blank/sync decode.
// Decodes use the next count so they land in the same register stage as the count.
module vga_timing_axis
    import vga_timing_pkg::*;
#(
    parameter int CNT_W  = 11,
    parameter int ACTIVE = 1024,
    parameter int FP     = 24,
    parameter int SYNC   = 136,
    parameter int BP     = 144,
    parameter bit POL    = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_adv,
    output logic [CNT_W-1:0] o_count,
    output logic             o_blnk,
    output logic             o_sync,
    output logic             o_wrap
);
    localparam int TOT      = vga_total(ACTIVE, FP, SYNC, BP);
    localparam int SYNC_BEG = ACTIVE + FP;
    localparam int SYNC_END = ACTIVE + FP + SYNC - 1;

    logic [CNT_W-1:0] r_count;
    logic             r_blnk;
    logic             r_sync;
    logic [CNT_W-1:0] w_next;
    logic             w_wrap;
    logic             w_sync_act;

    // Next position and its decodes
    always_comb begin
        w_wrap     = i_adv && (r_count == CNT_W'(TOT - 1));
        w_next     = r_count;
        if (w_wrap) begin
            w_next = {CNT_W{1'b0}};
        end else begin
            w_next = r_count + CNT_W'(1);
        end
        w_sync_act = (w_next >= CNT_W'(SYNC_BEG)) && (w_next <= CNT_W'(SYNC_END));
    end

    // Counter and decoded levels advance together, hold when not advancing
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= {CNT_W{1'b0}};
            r_blnk  <= 1'b0;
            r_sync  <= ~POL;
        end else if (i_adv) begin
            r_count <= w_next;
            r_blnk  <= (w_next >= CNT_W'(ACTIVE));
            r_sync  <= w_sync_act ? POL : ~POL;
        end
    end

    assign o_count = r_count;
    assign o_blnk  = r_blnk;
    assign o_sync  = r_sync;
    assign o_wrap  = w_wrap;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: counts, sync/blank and line/frame strobes.
// Optional 16-bit frame counter enabled by VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CNT_W    = vga_timing_pkg::CNT_W,
    parameter int H_ACTIVE = XGA_H_ACTIVE,
    parameter int H_FP     = XGA_H_FP,
    parameter int H_SYNC   = XGA_H_SYNC,
    parameter int H_BP     = XGA_H_BP,
    parameter int V_ACTIVE = XGA_V_ACTIVE,
    parameter int V_FP     = XGA_V_FP,
    parameter int V_SYNC   = XGA_V_SYNC,
    parameter int V_BP     = XGA_V_BP,
    parameter bit H_POL    = XGA_H_POL,
    parameter bit V_POL    = XGA_V_POL
) (
    input logic          pclk,
    input logic          rst,
    vga_timing_if.master vga
);
    localparam int H_TOT = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOT = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOT > (2 ** CNT_W)) begin : g_h_tot_err
        $error("vga_timing_gen: H_TOT does not fit in CNT_W bits");
    end
    if (V_TOT > (2 ** CNT_W)) begin : g_v_tot_err
        $error("vga_timing_gen: V_TOT does not fit in CNT_W bits");
    end
    if ((H_SYNC < 1) || (V_SYNC < 1)) begin : g_sync_err
        $error("vga_timing_gen: sync width must be at least 1");
    end

    logic w_h_wrap;
    logic w_v_wrap;
    logic w_v_adv;
    logic r_line_start;
    logic r_frame_start;

    assign w_v_adv = vga.ce & w_h_wrap;

    vga_timing_axis #(
        .CNT_W(CNT_W), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_POL)
    ) u_h_axis (
        .i_clk   (pclk),
        .i_rst_n (rst),
        .i_adv   (vga.ce),
        .o_count (vga.hcount),
        .o_blnk  (vga.hblnk),
        .o_sync  (vga.hsync),
        .o_wrap  (w_h_wrap)
    );

    vga_timing_axis #(
        .CNT_W(CNT_W), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_POL)
    ) u_v_axis (
        .i_clk   (pclk),
        .i_rst_n (rst),
        .i_adv   (w_v_adv),
        .o_count (vga.vcount),
        .o_blnk  (vga.vblnk),
        .o_sync  (vga.vsync),
        .o_wrap  (w_v_wrap)
    );

    // Strobes mark the edge that lands on position 0; wrap terms already include ce
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= w_h_wrap;
            r_frame_start <= w_v_wrap;
        end
    end

    assign vga.line_start  = r_line_start;
    assign vga.frame_start = r_frame_start;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    // Free-running frame count, steps on the same edge frame_start rises
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            r_frame_cnt <= 16'd0;
        end else if (w_v_wrap) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign vga.frame_cnt = r_frame_cnt;
`endif

endmodule
